// File: rtl/rj_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rj_pkg
// Shared definitions for the right-justified coefficient memory sequencer:
// data/address widths, memory depth, channel selectors and the sequencer
// state encoding.
// ---------------------------------------------------------------------------
package rj_pkg;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLR_SET = 3'd1,
      CLR_WE  = 3'd2,
      LD_SET  = 3'd3,
      LD_WE   = 3'd4,
      RUN     = 3'd5,
      DONE    = 3'd6
   } state_t;

endpackage

// File: rtl/rj_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// rj_mem_sequencer_if
// Bundles the host load handshake, the clear/frame requests and the memory
// side bus (row, write data, strobes, read index) plus status flags.
//   master : host/memory side (drives requests, observes everything else)
//   slave  : the sequencer (drives memory bus, handshake ready and flags)
// ---------------------------------------------------------------------------
interface rj_mem_sequencer_if;
   import rj_pkg::*;

   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_data;
   logic          load_chan;
   logic          clr_req;
   logic          frame_start;
   logic [AW-1:0] row;
   logic [DW-1:0] wr_data;
   logic          rjL_we;
   logic          rjR_we;
   logic [AW-1:0] index_rj;
   logic          idx_valid;
   logic          frame_done;
   logic          busy;
   logic          fullL;
   logic          fullR;
   logic          overrun;

   modport master (
      output load_valid, load_data, load_chan, clr_req, frame_start,
      input  load_ready, row, wr_data, rjL_we, rjR_we, index_rj, idx_valid,
             frame_done, busy, fullL, fullR, overrun
   );

   modport slave (
      input  load_valid, load_data, load_chan, clr_req, frame_start,
      output load_ready, row, wr_data, rjL_we, rjR_we, index_rj, idx_valid,
             frame_done, busy, fullL, fullR, overrun
   );

endinterface

// File: rtl/rj_mem_sequencer_wr_ptr.sv
// ---------------------------------------------------------------------------
// rj_wr_ptr
// Per-channel write pointer for one coefficient memory. Wraps 15 -> 0 and
// raises a sticky full flag on the wrap.
// Ports:
//   Sclk    : system clock, rising edge
//   clear_n : synchronous active-low reset
//   clr     : synchronous clear of pointer and full flag (end of sweep)
//   inc     : advance pointer by one row
//   ptr     : next row to be written
//   full    : a full set of rows has been written since the last clear
// ---------------------------------------------------------------------------
module rj_wr_ptr
   import rj_pkg::*;
(
   input  logic          Sclk,
   input  logic          clear_n,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] ptr,
   output logic          full
);

   // Pointer advances once per completed write; full latches on the wrap
   // so writes past full fall back onto row 0 while the flag stays set.
   always_ff @(posedge Sclk) begin
      if (!clear_n || clr) begin
         ptr  <= '0;
         full <= 1'b0;
      end else if (inc) begin
         ptr <= ptr + AW'(1);
         if (ptr == LAST_ROW) begin
            full <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rj_mem_sequencer.sv
// ---------------------------------------------------------------------------
// rj_mem_sequencer
// Controller for the left/right right-justified coefficient memories.
// Arbitrates host word loads, a zero-clear sweep of both memories and the
// per-frame 0..15 read-index scan so the memories never see conflicting
// strobes or indices. Every write drives row/data one cycle before a
// single-cycle strobe.
// Ports:
//   Sclk    : system clock, rising edge
//   clear_n : synchronous active-low reset
//   bus     : slave side of rj_mem_sequencer_if (host handshake, requests,
//             memory row/data/strobes, read index, status flags)
// ---------------------------------------------------------------------------
module rj_mem_sequencer
   import rj_pkg::*;
(
   input logic               Sclk,
   input logic               clear_n,
   rj_mem_sequencer_if.slave bus
);

   state_t        state;
   logic          ld_chan;
   logic          ready_q;
   logic [AW-1:0] row_q;
   logic [DW-1:0] wr_data_q;
   logic          we_l_q;
   logic          we_r_q;
   logic [AW-1:0] index_q;
   logic          idx_valid_q;
   logic          frame_done_q;
   logic          busy_q;
   logic          overrun_q;

   logic [AW-1:0] ptr_l;
   logic [AW-1:0] ptr_r;
   logic          full_l;
   logic          full_r;
   logic          inc_l;
   logic          inc_r;
   logic          ptr_clr;

   // Pointers advance during the strobe cycle of a load and are wiped on
   // the final strobe of a clear sweep.
   assign inc_l   = (state == LD_WE) && (ld_chan == CH_L);
   assign inc_r   = (state == LD_WE) && (ld_chan == CH_R);
   assign ptr_clr = (state == CLR_WE) && (row_q == LAST_ROW);

   rj_wr_ptr u_ptr_l (
      .Sclk    (Sclk),
      .clear_n (clear_n),
      .clr     (ptr_clr),
      .inc     (inc_l),
      .ptr     (ptr_l),
      .full    (full_l)
   );

   rj_wr_ptr u_ptr_r (
      .Sclk    (Sclk),
      .clear_n (clear_n),
      .clr     (ptr_clr),
      .inc     (inc_r),
      .ptr     (ptr_r),
      .full    (full_r)
   );

   // ready_q is the registered "sitting in IDLE" part of load_ready; the
   // same-cycle clear/frame requests mask it so the host never sees a
   // handshake that the arbitration would then refuse.
   assign bus.load_ready = ready_q & ~bus.clr_req & ~bus.frame_start;
   assign bus.row        = row_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.rjL_we     = we_l_q;
   assign bus.rjR_we     = we_r_q;
   assign bus.index_rj   = index_q;
   assign bus.idx_valid  = idx_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = busy_q;
   assign bus.fullL      = full_l;
   assign bus.fullR      = full_r;
   assign bus.overrun    = overrun_q;

   // Main sequencer. IDLE arbitrates clear > frame > load. SET states put
   // row/data on the bus, WE states raise the strobe for exactly one cycle.
   // A frame request seen outside IDLE is dropped and recorded in overrun;
   // the end of a clear sweep wipes overrun even if a request lands there.
   always_ff @(posedge Sclk) begin
      if (!clear_n) begin
         state        <= IDLE;
         ld_chan      <= CH_L;
         ready_q      <= 1'b0;
         row_q        <= '0;
         wr_data_q    <= '0;
         we_l_q       <= 1'b0;
         we_r_q       <= 1'b0;
         index_q      <= '0;
         idx_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (bus.frame_start && (state != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state     <= CLR_SET;
                  row_q     <= '0;
                  wr_data_q <= '0;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
               end else if (bus.frame_start) begin
                  state       <= RUN;
                  index_q     <= '0;
                  idx_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  ready_q     <= 1'b0;
               end else if (bus.load_valid && ready_q) begin
                  state     <= LD_SET;
                  ld_chan   <= bus.load_chan;
                  wr_data_q <= bus.load_data;
                  row_q     <= (bus.load_chan == CH_R) ? ptr_r : ptr_l;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            CLR_SET: begin
               state  <= CLR_WE;
               we_l_q <= 1'b1;
               we_r_q <= 1'b1;
            end
            CLR_WE: begin
               we_l_q <= 1'b0;
               we_r_q <= 1'b0;
               if (row_q == LAST_ROW) begin
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
                  overrun_q <= 1'b0;
               end else begin
                  state <= CLR_SET;
                  row_q <= row_q + AW'(1);
               end
            end
            LD_SET: begin
               state <= LD_WE;
               if (ld_chan == CH_R) begin
                  we_r_q <= 1'b1;
               end else begin
                  we_l_q <= 1'b1;
               end
            end
            LD_WE: begin
               state   <= IDLE;
               we_l_q  <= 1'b0;
               we_r_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            RUN: begin
               if (index_q == LAST_ROW) begin
                  state        <= DONE;
                  index_q      <= '0;
                  idx_valid_q  <= 1'b0;
                  frame_done_q <= 1'b1;
               end else begin
                  index_q <= index_q + AW'(1);
               end
            end
            DONE: begin
               state        <= IDLE;
               frame_done_q <= 1'b0;
               busy_q       <= 1'b0;
               ready_q      <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               we_l_q       <= 1'b0;
               we_r_q       <= 1'b0;
               idx_valid_q  <= 1'b0;
               frame_done_q <= 1'b0;
               busy_q       <= 1'b0;
               ready_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rj_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rj_mem_sequencer
// Self-checking bench for rj_mem_sequencer. A transaction-level model turns
// each accepted operation (load, clear sweep, frame scan) into the list of
// bus values it must produce, cycle by cycle; a compare process checks the
// DUT against it on every falling edge. Directed scenarios add literal
// expectations, then a randomized phase exercises arbitration and resets.
// ---------------------------------------------------------------------------
module tb_rj_mem_sequencer;
   import rj_pkg::*;

   logic Sclk = 1'b0;
   logic clear_n;

   rj_mem_sequencer_if bus ();

   rj_mem_sequencer dut (
      .Sclk    (Sclk),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 Sclk = ~Sclk;

   typedef struct {
      logic [3:0]  row;
      logic [15:0] data;
      logic        we_l;
      logic        we_r;
      logic [3:0]  idx;
      logic        iv;
      logic        fd;
      logic        busy;
      logic        ready;
      int          act;
   } vec_t;

   vec_t       cur;
   vec_t       plan[$];
   logic [3:0] m_ptr_l;
   logic [3:0] m_ptr_r;
   logic       m_full_l;
   logic       m_full_r;
   logic       m_overrun;
   bit         model_valid = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Bus value held while no operation runs: row/data keep their last
   // value, scan outputs return to rest and the host may hand over a word.
   function automatic vec_t idle_vec(input vec_t prev);
      vec_t v;
      v       = prev;
      v.we_l  = 1'b0;
      v.we_r  = 1'b0;
      v.idx   = 4'd0;
      v.iv    = 1'b0;
      v.fd    = 1'b0;
      v.busy  = 1'b0;
      v.ready = 1'b1;
      v.act   = 0;
      return v;
   endfunction

   function automatic vec_t busy_vec(input vec_t prev);
      vec_t v;
      v       = idle_vec(prev);
      v.busy  = 1'b1;
      v.ready = 1'b0;
      return v;
   endfunction

   // Bookkeeping performed when an operation finishes and the bus is idle
   // again: 1/2 = a word landed in left/right memory, 3 = sweep finished.
   task automatic apply_act(input int act);
      if (act == 1) begin
         if (m_ptr_l == 4'd15) m_full_l = 1'b1;
         m_ptr_l = m_ptr_l + 4'd1;
      end else if (act == 2) begin
         if (m_ptr_r == 4'd15) m_full_r = 1'b1;
         m_ptr_r = m_ptr_r + 4'd1;
      end else if (act == 3) begin
         m_ptr_l   = 4'd0;
         m_ptr_r   = 4'd0;
         m_full_l  = 1'b0;
         m_full_r  = 1'b0;
         m_overrun = 1'b0;
      end
   endtask

   // Advance the model by one clock: replay the planned bus values of the
   // running operation, or in idle pick the winning request and plan it.
   task automatic model_step();
      vec_t v;
      if (!clear_n) begin
         plan.delete();
         cur         = '{default: 0};
         m_ptr_l     = 4'd0;
         m_ptr_r     = 4'd0;
         m_full_l    = 1'b0;
         m_full_r    = 1'b0;
         m_overrun   = 1'b0;
         model_valid = 1'b1;
         return;
      end
      if (!model_valid) return;
      if (bus.frame_start && cur.busy) m_overrun = 1'b1;
      if (plan.size() != 0) begin
         cur = plan.pop_front();
         apply_act(cur.act);
      end else if (bus.clr_req) begin
         v      = busy_vec(cur);
         v.data = 16'h0000;
         for (int r = 0; r < 16; r++) begin
            v.row  = 4'(r);
            v.we_l = 1'b0;
            v.we_r = 1'b0;
            plan.push_back(v);
            v.we_l = 1'b1;
            v.we_r = 1'b1;
            plan.push_back(v);
         end
         v     = idle_vec(v);
         v.act = 3;
         plan.push_back(v);
         cur = plan.pop_front();
      end else if (bus.frame_start) begin
         v = busy_vec(cur);
         for (int i = 0; i < 16; i++) begin
            v.idx = 4'(i);
            v.iv  = 1'b1;
            plan.push_back(v);
         end
         v.idx = 4'd0;
         v.iv  = 1'b0;
         v.fd  = 1'b1;
         plan.push_back(v);
         plan.push_back(idle_vec(v));
         cur = plan.pop_front();
      end else if (bus.load_valid && cur.ready) begin
         v      = busy_vec(cur);
         v.data = bus.load_data;
         v.row  = bus.load_chan ? m_ptr_r : m_ptr_l;
         plan.push_back(v);
         if (bus.load_chan) v.we_r = 1'b1;
         else               v.we_l = 1'b1;
         plan.push_back(v);
         v     = idle_vec(v);
         v.act = bus.load_chan ? 2 : 1;
         plan.push_back(v);
         cur = plan.pop_front();
      end else begin
         cur = idle_vec(cur);
      end
   endtask

   initial begin
      forever begin
         @(posedge Sclk);
         model_step();
      end
   end

   function automatic logic [32:0] outs();
      return {bus.row, bus.wr_data, bus.rjL_we, bus.rjR_we, bus.index_rj,
              bus.idx_valid, bus.frame_done, bus.busy, bus.fullL, bus.fullR,
              bus.overrun, bus.load_ready};
   endfunction

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      logic [32:0] got;
      logic [32:0] exp;
      forever begin
         @(negedge Sclk);
         if (model_valid) begin
            got = outs();
            exp = {cur.row, cur.data, cur.we_l, cur.we_r, cur.idx, cur.iv,
                   cur.fd, cur.busy, m_full_l, m_full_r, m_overrun,
                   cur.ready & ~bus.clr_req & ~bus.frame_start};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("[TB] FAIL model_cmp t=%0t got=%h exp=%h", $time, got, exp);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the next rising edge sample them, and
   // return shortly after that edge with outputs settled.
   task automatic applyStimulus(input logic lv, input logic ch, input logic [15:0] d,
                                input logic clr, input logic fs);
      bus.load_valid  = lv;
      bus.load_chan   = ch;
      bus.load_data   = d;
      bus.clr_req     = clr;
      bus.frame_start = fs;
      @(posedge Sclk);
      #2;
   endtask

   task automatic tick_idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // Full load transaction from idle; reports what the bus showed in the
   // data cycle and the strobe cycle, returns once ready again.
   task automatic do_load(input logic ch, input logic [15:0] d, output logic [3:0] row_seen,
                          output logic [15:0] data_seen, output logic wl, output logic wr);
      applyStimulus(1'b1, ch, d, 1'b0, 1'b0);
      row_seen  = bus.row;
      data_seen = bus.wr_data;
      tick_idle(1);
      wl = bus.rjL_we;
      wr = bus.rjR_we;
      tick_idle(1);
   endtask

   initial begin
      logic [3:0]  r;
      logic [15:0] d;
      logic        wl;
      logic        wr;
      int          busy_cnt;
      int          strobe_cnt;
      bit          order_ok;
      int          idx_cnt;
      int          done_cnt;
      int          ready_busy;
      bit          found;
      logic        fs;

      clear_n = 1'b0;
      tick_idle(3);
      checkOutput("reset_all_zero", 64'(outs()), 64'd0);

      clear_n = 1'b1;
      tick_idle(1);
      checkOutput("ready_after_reset", bus.load_ready, 1);
      checkOutput("idle_not_busy", bus.busy, 0);

      applyStimulus(1'b1, CH_L, 16'h1234, 1'b0, 1'b0);
      checkOutput("load1_row", bus.row, 0);
      checkOutput("load1_data", bus.wr_data, 16'h1234);
      checkOutput("load1_no_early_we", {bus.rjL_we, bus.rjR_we}, 0);
      tick_idle(1);
      checkOutput("load1_strobe", {bus.rjL_we, bus.rjR_we}, 2'b10);
      tick_idle(1);
      checkOutput("load1_strobe_off", {bus.rjL_we, bus.rjR_we}, 0);
      checkOutput("load1_ready_again", bus.load_ready, 1);

      do_load(CH_R, 16'hABCD, r, d, wl, wr);
      checkOutput("loadR_row", r, 0);
      checkOutput("loadR_data", d, 16'hABCD);
      checkOutput("loadR_strobe", {wl, wr}, 2'b01);

      do_load(CH_L, 16'h0001, r, d, wl, wr);
      checkOutput("loadL2_row", r, 1);

      for (int i = 0; i < 14; i++) begin
         if (i == 13) checkOutput("fullL_before_16", bus.fullL, 0);
         do_load(CH_L, 16'(i + 2), r, d, wl, wr);
      end
      checkOutput("fullL_after_16", bus.fullL, 1);
      checkOutput("fullR_stays_0", bus.fullR, 0);
      do_load(CH_L, 16'h0F0F, r, d, wl, wr);
      checkOutput("load17_wraps_row", r, 0);

      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      busy_cnt   = 0;
      strobe_cnt = 0;
      order_ok   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) busy_cnt++;
         if (bus.rjL_we && bus.rjR_we) begin
            if (bus.row != 4'(strobe_cnt) || bus.wr_data != 16'h0000) order_ok = 1'b0;
            strobe_cnt++;
         end
         applyStimulus(1'b0, 1'b0, 16'h0000, (i == 10), 1'b0);
      end
      checkOutput("sweep_busy_cycles", busy_cnt, 32);
      checkOutput("sweep_strobes", strobe_cnt, 16);
      checkOutput("sweep_row_order", order_ok, 1);
      checkOutput("sweep_clears_fullL", bus.fullL, 0);
      do_load(CH_L, 16'h7777, r, d, wl, wr);
      checkOutput("post_sweep_row", r, 0);

      applyStimulus(1'b1, CH_L, 16'h5555, 1'b0, 1'b1);
      idx_cnt    = 0;
      done_cnt   = 0;
      ready_busy = 0;
      order_ok   = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (bus.idx_valid) begin
            if (bus.index_rj != 4'(idx_cnt)) order_ok = 1'b0;
            idx_cnt++;
         end
         if (bus.frame_done) done_cnt++;
         if (bus.busy && bus.load_ready) ready_busy++;
         fs = bus.idx_valid && (bus.index_rj == 4'd7);
         applyStimulus(done_cnt == 0, CH_L, 16'h5555, 1'b0, fs);
      end
      checkOutput("scan_index_count", idx_cnt, 16);
      checkOutput("scan_index_order", order_ok, 1);
      checkOutput("scan_done_pulses", done_cnt, 1);
      checkOutput("scan_ready_low", ready_busy, 0);
      checkOutput("scan_overrun", bus.overrun, 1);

      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.busy && bus.row == 4'd5 && !bus.rjL_we) found = 1'b1;
         else tick_idle(1);
      end
      checkOutput("reach_row5", found, 1);
      clear_n = 1'b0;
      tick_idle(1);
      checkOutput("reset_mid_sweep", 64'(outs()), 64'd0);
      clear_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick_idle(1);
         checkOutput("no_strobe_after_reset", {bus.rjL_we, bus.rjR_we}, 0);
      end

      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      checkOutput("clr_wins_busy", bus.busy, 1);
      checkOutput("clr_wins_no_scan", bus.idx_valid, 0);
      checkOutput("clr_wins_overrun", bus.overrun, 0);
      tick_idle(1);
      checkOutput("clr_wins_strobe", {bus.rjL_we, bus.rjR_we}, 2'b11);
      tick_idle(35);

      for (int i = 0; i < 3000; i++) begin
         clear_n = ($urandom_range(0, 199) != 0);
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4));
      end
      clear_n = 1'b1;
      tick_idle(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rj_mem_sequencer.md
Name: rj_mem_sequencer

Overview:
- Controller for the left/right right-justified coefficient memories (16 x 16-bit, one per channel).
- Each memory writes on the rising edge of its write strobe and has a combinational read index.
- Sequences three things: host word loads into the correct channel/row, a full zero-clear sweep, and a per-frame 0..15 read-index scan for the processing datapath.
- Arbitrates between these three so that no strobe or index conflict ever reaches the memories.

Parameters:
- DW, 16, data word width
- AW, 4, row/index address width
- DEPTH, 16, rows per memory; must equal 2**AW

Ports:
- Sclk  in  1  system clock; all logic on rising edge
- clear_n  in  1  synchronous active-low reset
- load_valid  in  1  host offers a word
- load_ready  out  1  sequencer accepts the word this cycle
- load_data  in  DW  host word
- load_chan  in  1  0 = left, 1 = right
- clr_req  in  1  request zero-clear sweep of both memories
- frame_start  in  1  single-cycle pulse: begin index scan
- row  out  AW  write row to memories
- wr_data  out  DW  write data to memories
- rjL_we  out  1  left memory write strobe
- rjR_we  out  1  right memory write strobe
- index_rj  out  AW  read index to both memories
- idx_valid  out  1  index_rj is a live scan index
- frame_done  out  1  one-cycle pulse after the last index
- busy  out  1  state != IDLE
- fullL  out  1  16 left words loaded since last clear
- fullR  out  1  16 right words loaded since last clear
- overrun  out  1  sticky: frame_start arrived while not IDLE

Behaviour:
- Reset (clear_n = 0 at a rising edge), all outputs 0:
  - state = IDLE; row, wr_data, index_rj, both write pointers = 0.
  - All strobes low, load_ready = 0, flags clear.
  - Reset mid-sweep or mid-write aborts immediately; no strobe pulse follows.
- States: IDLE, CLR_SET, CLR_WE, LD_SET, LD_WE, RUN, DONE.
- Strobe timing (all writes): row/wr_data are driven in a SET cycle and held through the following WE cycle, so they are stable one cycle before the strobe edge. A strobe is never high two consecutive cycles.
- IDLE priority, highest first:
  - clr_req -> CLR_SET with row = 0.
  - frame_start -> RUN.
  - load_valid -> LD_SET.
  - load_ready = 1 only in IDLE when clr_req = 0 and frame_start = 0.
  - Handshake: load_valid & load_ready latches load_data/load_chan.
- Load path:
  - LD_SET: wr_data = latched word; row = wrptr of the selected channel.
  - LD_WE: selected strobe high for one cycle, that channel's wrptr increments (wraps 15 -> 0), then -> IDLE.
  - Latency: accepted at cycle N -> row/data valid N+1 -> strobe N+2 -> load_ready high again N+3 (if no higher-priority request).
  - full flag sets when its wrptr wraps 15 -> 0; cleared only by a clear sweep or reset.
  - Writes past full overwrite row 0 onward.
- Clear sweep:
  - CLR_SET (wr_data = 0, row = r) alternates with CLR_WE (rjL_we = rjR_we = 1) for r = 0..15: 32 cycles total.
  - After r = 15, CLR_WE -> IDLE and clears wrptrs, fullL, fullR and overrun.
  - clr_req re-asserted during a sweep is ignored; the sweep does not restart.
- Run scan:
  - RUN: idx_valid = 1; index_rj = 0,1,...,15 on consecutive cycles (16 cycles); no strobes.
  - DONE: frame_done = 1 and idx_valid = 0 for one cycle, index_rj returns to 0, then -> IDLE.
  - frame_start while not IDLE is dropped and sets overrun.
- Simultaneous events: frame_start and clr_req in the same IDLE cycle -> clear wins; the frame pulse is dropped and overrun is not set.

Decomposition:
- Shared package rj_pkg holds:
  - State encoding enum (7 states, 3-bit).
  - Constants DW = 16, AW = 4, DEPTH = 16.
  - Channel constants CH_L = 0, CH_R = 1.
- One natural sub-module, rj_wr_ptr: a per-channel 4-bit wrapping pointer with an increment enable, a sync clear and a full flag; instantiated twice.
- FSM, arbitration and run counter stay in the top module.

Test Plan:
- Reset then idle: all outputs 0 after reset; load_ready = 1 one cycle after clear_n rises; busy = 0.
- Load L 0x1234 then R 0xABCD:
  - First load: row = 0, wr_data = 0x1234 at N+1; rjL_we pulse at N+2 only.
  - Second load: rjR_we pulse with row = 0, wr_data = 0xABCD.
  - Third L load targets row 1.
- Sixteen L loads (0x0000..0x000F): fullL rises after the 16th strobe; a 17th load writes row 0; fullR stays 0.
- clr_req after loads:
  - 16 dual-strobe pulses with wr_data = 0 on rows 0..15 in order, busy for 32 cycles.
  - Afterwards fullL = 0 and the next L load targets row 0.
- frame_start from IDLE:
  - index_rj 0..15 with idx_valid high for exactly 16 cycles, then a single frame_done pulse.
  - A second frame_start at index 7 sets overrun without disturbing the scan.
  - load_valid held throughout the scan sees load_ready = 0.
- Reset mid-sweep at row 5: all outputs 0 on the next cycle with no further strobe; clr_req + frame_start together -> clear sweep, overrun = 0.
